// File: rtl/accumulator_pkg.sv
// ---------------------------------------------------------------------------
// accumulator_pkg
// Shared definitions for the signed accumulator slice.
//   op_t            : operation codes carried on the 2-bit op port
//   DEFAULT_N_BITS  : default data / accumulator width
// ---------------------------------------------------------------------------
package accumulator_pkg;

  // Operation codes; the numeric values are the wire encoding on op.
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    ADD  = 2'b01,
    SUB  = 2'b10,
    LOAD = 2'b11
  } op_t;

  localparam int DEFAULT_N_BITS = 8;

endpackage : accumulator_pkg

// File: rtl/signed_accumulator_flag_gen.sv
// ---------------------------------------------------------------------------
// flag_gen
// Purely combinational status flags derived from the registered accumulator.
// Ports:
//   i_acc        : accumulator value (signed, N_BITS wide)
//   o_isNegative : 1 when i_acc < 0
//   o_isZero     : 1 when i_acc == 0
//   o_isEven     : 1 when bit 0 of i_acc is 0
// ---------------------------------------------------------------------------
module flag_gen #(
  parameter int N_BITS = 8
) (
  input  logic signed [N_BITS-1:0] i_acc,
  output logic                     o_isNegative,
  output logic                     o_isZero,
  output logic                     o_isEven
);

  // Sign bit gives negativity directly; zero and parity are simple reductions.
  assign o_isNegative = i_acc[N_BITS-1];
  assign o_isZero     = (i_acc == '0);
  assign o_isEven     = ~i_acc[0];

endmodule : flag_gen

// File: rtl/signed_accumulator.sv
// ---------------------------------------------------------------------------
// signed_accumulator
// Signed accumulator with HOLD / ADD / SUB / LOAD operations, optional
// saturation, a sticky signed-overflow flag and combinational status flags.
// Ports:
//   clock       : rising-edge clock
//   reset       : asynchronous active-high reset
//   clear       : synchronous clear of acc and overflow (beats in_valid)
//   in_valid    : qualifies op and operand
//   op          : operation code (see accumulator_pkg::op_t)
//   operand     : signed data operand
//   acc         : registered accumulator value
//   done        : one-cycle pulse after each accepted operation
//   is_negative : acc < 0
//   is_zero     : acc == 0
//   is_even     : acc bit 0 == 0
//   overflow    : sticky signed-overflow flag
// ---------------------------------------------------------------------------
module signed_accumulator
  import accumulator_pkg::*;
#(
  parameter int N_BITS   = DEFAULT_N_BITS,
  parameter bit SATURATE = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [1:0]               op,
  input  logic signed [N_BITS-1:0] operand,
  output logic signed [N_BITS-1:0] acc,
  output logic                     done,
  output logic                     is_negative,
  output logic                     is_zero,
  output logic                     is_even,
  output logic                     overflow
);

  localparam logic [N_BITS-1:0] MAX_VAL = {1'b0, {(N_BITS-1){1'b1}}};
  localparam logic [N_BITS-1:0] MIN_VAL = {1'b1, {(N_BITS-1){1'b0}}};

  logic signed [N_BITS-1:0] r_acc;
  logic                     r_overflow;
  logic                     r_done;

  logic [N_BITS:0]          w_sum;
  logic [N_BITS:0]          w_diff;
  logic [N_BITS-1:0]        w_satVal;
  logic [N_BITS-1:0]        w_accNext;
  logic                     w_overflowNext;
  logic                     w_doneNext;
  logic                     w_opOverflow;

  // Next-state logic. Sums are formed one bit wider than the data so the
  // wrapped result is simply the low N_BITS. When an ADD or SUB overflows,
  // the true result always has the sign of the current accumulator (ADD only
  // overflows with like-signed inputs, SUB only when the operand's sign is
  // opposite to acc), so the saturation limit is picked from acc's sign.
  always_comb begin
    w_sum          = {r_acc[N_BITS-1], r_acc} + {operand[N_BITS-1], operand};
    w_diff         = {r_acc[N_BITS-1], r_acc} - {operand[N_BITS-1], operand};
    w_satVal       = r_acc[N_BITS-1] ? MIN_VAL : MAX_VAL;
    w_accNext      = r_acc;
    w_overflowNext = r_overflow;
    w_doneNext     = 1'b0;
    w_opOverflow   = 1'b0;

    if (clear) begin
      w_accNext      = '0;
      w_overflowNext = 1'b0;
      w_doneNext     = 1'b0;
    end else if (in_valid) begin
      w_doneNext = 1'b1;
      case (op_t'(op))
        ADD: begin
          w_opOverflow = (r_acc[N_BITS-1] == operand[N_BITS-1]) &&
                         (w_sum[N_BITS-1] != r_acc[N_BITS-1]);
          w_accNext    = w_sum[N_BITS-1:0];
        end
        SUB: begin
          w_opOverflow = (r_acc[N_BITS-1] != operand[N_BITS-1]) &&
                         (w_diff[N_BITS-1] != r_acc[N_BITS-1]);
          w_accNext    = w_diff[N_BITS-1:0];
        end
        LOAD: begin
          w_accNext = operand;
        end
        default: begin
          w_accNext = r_acc;
        end
      endcase

      if (w_opOverflow) begin
        w_overflowNext = 1'b1;
        if (SATURATE) begin
          w_accNext = w_satVal;
        end
      end
    end
  end

  // State update: the only registers are acc, overflow and done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc      <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_acc      <= w_accNext;
      r_overflow <= w_overflowNext;
      r_done     <= w_doneNext;
    end
  end

  assign acc      = r_acc;
  assign overflow = r_overflow;
  assign done     = r_done;

  flag_gen #(
    .N_BITS(N_BITS)
  ) u_flagGen (
    .i_acc        (r_acc),
    .o_isNegative (is_negative),
    .o_isZero     (is_zero),
    .o_isEven     (is_even)
  );

endmodule : signed_accumulator

// File: doc/signed_accumulator.md
SIGNED_ACCUMULATOR -- requirements
Module: signed_accumulator

Interface
REQ-001 Parameter N_BITS, default 8, gives the data and accumulator width in bits (N_BITS >= 2).
REQ-002 Parameter SATURATE, default 0, selects overflow handling: 0 = two's-complement wrap, 1 = clamp to the limit.
REQ-003 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port clear, input, 1 bit: synchronous clear of the accumulator and the sticky overflow.
REQ-006 Port in_valid, input, 1 bit: operation request, qualifies op and operand.
REQ-007 Port op, input, 2 bits: operation code, see REQ-012.
REQ-008 Port operand, input, N_BITS, signed: data operand.
REQ-009 Port acc, output, N_BITS, signed: registered accumulator value.
REQ-010 Port done, output, 1 bit: one-cycle pulse, the accumulator was updated by an accepted operation.
REQ-011 Ports is_negative, is_zero, is_even, overflow: outputs, 1 bit each. The first three are flags of acc. overflow is a sticky signed-overflow flag.

Function
REQ-012 Op codes: 00 HOLD (acc unchanged), 01 ADD (acc+operand), 10 SUB (acc-operand), 11 LOAD (acc=operand).
REQ-013 Operation accepted at a rising edge where in_valid=1 and clear=0. Result appears on acc exactly 1 cycle later, with no back-pressure. A new operation may be accepted every cycle.
REQ-014 done = 1 in the cycle after any accepted operation, HOLD included; otherwise 0.
REQ-015 Arithmetic computed at N_BITS+1 bits, signed. Signed overflow condition:
  - ADD: acc and operand have the same sign and the result sign differs.
  - SUB: acc and operand have different signs and the result sign differs from acc.
  - LOAD and HOLD never overflow.
REQ-016 Overflow with SATURATE=0: acc takes the low N_BITS of the result (wrap).
REQ-017 Overflow with SATURATE=1: acc takes 2^(N_BITS-1)-1 on positive overflow and -2^(N_BITS-1) on negative overflow.
REQ-018 overflow sets on the edge that commits an overflowing operation. It stays 1 until clear or reset.
REQ-019 clear=1 at an edge: acc=0, overflow=0, done=0. clear takes priority over a simultaneous in_valid, and that operation is discarded.
REQ-020 Flag definitions, all combinational from the registered acc, so always consistent with acc:
  - is_negative = acc < 0
  - is_zero = acc == 0
  - is_even = acc bit 0 == 0
REQ-021 in_valid=0 and clear=0: acc, overflow unchanged; done=0.

Reset
REQ-022 Reset asserted forces, without a clock edge: acc=0, done=0, overflow=0. Consequently is_negative=0, is_zero=1, is_even=1.
REQ-023 An operation in flight when reset asserts is lost. The first operation is accepted at the first rising edge after reset deasserts.

Structure
REQ-024 Package accumulator_pkg holds the op_t enum (HOLD, ADD, SUB, LOAD) and the N_BITS default constant.
REQ-025 Sub-module flag_gen (combinational, parametrised by N_BITS) derives is_negative, is_zero and is_even from acc; it is instantiated once.
REQ-026 Registered state is limited to acc, overflow and done; the next-state logic is a single always_comb, and the state update is a single always_ff.

Verification
REQ-027 Reset, no ops -> acc=0, is_zero=1, is_even=1, is_negative=0, overflow=0, done=0.
REQ-028 N_BITS=8: LOAD 5, then ADD 3 on consecutive cycles -> acc=5 then 8, done high 2 cycles, is_even=1 after the ADD.
REQ-029 SATURATE=0: LOAD 127, ADD 1 -> acc=-128, is_negative=1, overflow=1. A following LOAD 2 -> acc=2, overflow still 1.
REQ-030 SATURATE=1: LOAD -128, SUB 1 -> acc=-128, overflow=1. Then LOAD 100, ADD 100 -> acc=127.
REQ-031 LOAD 9, then clear=1 with in_valid=1 op ADD 4 in the same cycle -> acc=0, overflow=0, done=0, is_zero=1.
REQ-032 LOAD 7 accepted, reset pulsed between clock edges -> acc=0 and is_zero=1 immediately. The first post-reset ADD 3 gives acc=3.
